// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : fpu_pkg
// Brief  : Shared constants and state encoding for the FPU alignment stage.
// Rev    : 1.0  initial release
// ============================================================================
package fpu_pkg;

  localparam int MANTISSA_SIZE_DEFAULT = 23;
  localparam int MAX_ALIGN_SHIFT       = MANTISSA_SIZE_DEFAULT + 3;
  localparam int SHIFT_CNT_W           = $clog2(MANTISSA_SIZE_DEFAULT + 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_operand_compare.sv
`default_nettype none
// ============================================================================
// Module : fpu_operand_compare
// Brief  : Unpacks two operands, picks the larger effective exponent and
//          returns the absolute exponent difference.
// Rev    : 1.0  initial release
// ============================================================================
module fpu_operand_compare #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
) (
  input  logic [Exponent_Size-1:0] a_exponent,
  input  logic [Mantissa_Size-1:0] a_mantissa,
  input  logic [Exponent_Size-1:0] b_exponent,
  input  logic [Mantissa_Size-1:0] b_mantissa,
  output logic [Mantissa_Size:0]   big_sig,
  output logic [Mantissa_Size:0]   small_sig,
  output logic [Exponent_Size-1:0] big_exp,
  output logic                     swap,
  output logic [Exponent_Size-1:0] diff
);

  logic [Mantissa_Size:0]   w_sig_a, w_sig_b;
  logic [Exponent_Size-1:0] w_eff_a, w_eff_b;
  logic [Exponent_Size:0]   w_sub;

  // Denormals and zero behave as exponent 1 with no hidden bit.
  assign w_sig_a = {(a_exponent != '0), a_mantissa};
  assign w_sig_b = {(b_exponent != '0), b_mantissa};
  assign w_eff_a = (a_exponent == '0) ? Exponent_Size'(1) : a_exponent;
  assign w_eff_b = (b_exponent == '0) ? Exponent_Size'(1) : b_exponent;

  assign w_sub     = {1'b0, w_eff_a} - {1'b0, w_eff_b};
  assign swap      = w_sub[Exponent_Size];
  assign diff      = swap ? (w_eff_b - w_eff_a) : w_sub[Exponent_Size-1:0];
  assign big_sig   = swap ? w_sig_b : w_sig_a;
  assign small_sig = swap ? w_sig_a : w_sig_b;
  assign big_exp   = swap ? w_eff_b : w_eff_a;

endmodule : fpu_operand_compare
`default_nettype wire

// File: rtl/fpu_aligner.sv
`default_nettype none
// ============================================================================
// Module : fpu_aligner
// Brief  : Pre-add alignment stage; shifts the smaller significand right one
//          bit per cycle, producing guard/round/sticky.
// Rev    : 1.0  initial release
// ============================================================================
module fpu_aligner
  import fpu_pkg::*;
#(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Exponent_Size-1:0] a_exponent,
  input  logic [Mantissa_Size-1:0] a_mantissa,
  input  logic [Exponent_Size-1:0] b_exponent,
  input  logic [Mantissa_Size-1:0] b_mantissa,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Mantissa_Size:0]   big_mantissa,
  output logic [Mantissa_Size:0]   small_mantissa,
  output logic                     guard,
  output logic                     round,
  output logic                     sticky,
  output logic [Exponent_Size-1:0] common_exponent,
  output logic                     swapped
);

  localparam int c_work_w = Mantissa_Size + 3;
  localparam int c_cnt_w  = $clog2(Mantissa_Size + 4);
  localparam logic [Exponent_Size-1:0] c_max_shift = Exponent_Size'(Mantissa_Size + 3);

  align_state_t             r_state, w_next;
  logic [c_work_w-1:0]      r_work;
  logic [Mantissa_Size:0]   r_big;
  logic [Exponent_Size-1:0] r_exp;
  logic [c_cnt_w-1:0]       r_cnt;
  logic                     r_sticky, r_swapped;

  logic [Mantissa_Size:0]   w_big_sig, w_small_sig;
  logic [Exponent_Size-1:0] w_big_exp, w_diff;
  logic                     w_swap;
  logic [c_cnt_w-1:0]       w_cnt_init;

  fpu_operand_compare #(
    .Mantissa_Size(Mantissa_Size),
    .Exponent_Size(Exponent_Size)
  ) u_compare (
    .a_exponent(a_exponent),
    .a_mantissa(a_mantissa),
    .b_exponent(b_exponent),
    .b_mantissa(b_mantissa),
    .big_sig   (w_big_sig),
    .small_sig (w_small_sig),
    .big_exp   (w_big_exp),
    .swap      (w_swap),
    .diff      (w_diff)
  );

  // Beyond the cap every bit has already reached sticky, so clamping is exact.
  assign w_cnt_init = (w_diff > c_max_shift) ? c_cnt_w'(c_max_shift) : c_cnt_w'(w_diff);

  assign in_ready = (r_state == IDLE) && !rst;

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    if (in_valid) w_next = (w_cnt_init != '0) ? SHIFT : DONE;
      SHIFT:   if (r_cnt == c_cnt_w'(1)) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_big     <= '0;
      r_exp     <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      r_swapped <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (in_valid) begin
          r_work    <= {w_small_sig, 2'b00};
          r_big     <= w_big_sig;
          r_exp     <= w_big_exp;
          r_cnt     <= w_cnt_init;
          r_sticky  <= 1'b0;
          r_swapped <= w_swap;
        end
        SHIFT: begin
          r_work   <= r_work >> 1;
          r_sticky <= r_sticky | r_work[0];
          r_cnt    <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign big_mantissa    = r_big;
  assign small_mantissa  = r_work[c_work_w-1:2];
  assign guard           = r_work[1];
  assign round           = r_work[0];
  assign sticky          = r_sticky;
  assign common_exponent = r_exp;
  assign swapped         = r_swapped;

endmodule : fpu_aligner
`default_nettype wire
